// File: rtl/filter_pkg.sv
// Shared types and window geometry for the 9x9 filter scheduler.
package filter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int WIN       = 9;
  localparam int WIN_HALF  = 4;
  localparam int WIN_PIX   = 81;
  localparam int LOAD_CYC  = 82;
  localparam int PIX_W_DEF = 10;

endpackage

// File: rtl/window_addr_gen.sv
// Maps a window offset (dx,dy) around centre (cx,cy) to a source address,
// flagging coordinates that fall outside the image.
module window_addr_gen
  import filter_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic [3:0]        dx,
  input  logic [3:0]        dy,
  input  logic [ADDR_W-1:0] cx,
  input  logic [ADDR_W-1:0] cy,
  output logic              in_image,
  output logic [ADDR_W-1:0] addr
);

  localparam int SW = ADDR_W + 2;
  localparam logic signed [SW-1:0] W_S    = SW'(IMG_W);
  localparam logic signed [SW-1:0] H_S    = SW'(IMG_H);
  localparam logic signed [SW-1:0] HALF_S = SW'(WIN_HALF);

  logic signed [SW-1:0] x;
  logic signed [SW-1:0] y;

  always_comb begin
    x = $signed({2'b00, cx}) + $signed(SW'(dx)) - HALF_S;
    y = $signed({2'b00, cy}) + $signed(SW'(dy)) - HALF_S;
    in_image = !x[SW-1] && (x < W_S) && !y[SW-1] && (y < H_S);
    addr = ADDR_W'(y * W_S + x);
  end

endmodule

// File: rtl/filter_window_scheduler.sv
// Raster-scan sequencer: gathers each 9x9 neighbourhood, triggers the filter
// datapath, waits its latency and writes the result pixel.
module filter_window_scheduler
  import filter_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = 12,
  parameter int OP_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic [PIX_W-1:0]         mem_rd_data,
  output logic [WIN_PIX*PIX_W-1:0] op_data_bus,
  output logic                     op_refresh,
  input  logic [PIX_W-1:0]         op_out,
  output logic                     res_wr_en,
  output logic [ADDR_W-1:0]        res_wr_addr,
  output logic [PIX_W-1:0]         res_wr_data
);

  localparam int LW = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;
  localparam logic [6:0]        SLOT_LAST = 7'(WIN_PIX - 1);
  localparam logic [6:0]        DRAIN_CYC = 7'(LOAD_CYC - 1);
  localparam logic [3:0]        D_LAST    = 4'(WIN - 1);
  localparam logic [LW-1:0]     LAT_LAST  = LW'(OP_LAT - 1);
  localparam logic [ADDR_W-1:0] X_LAST    = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] Y_LAST    = ADDR_W'(IMG_H - 1);

  state_t state, next_state;

  logic [6:0]        cnt;
  logic [3:0]        dx, dy;
  logic [ADDR_W-1:0] cx, cy, centre_addr;
  logic [LW-1:0]     lat_cnt;
  logic [PIX_W-1:0]  result;
  logic              fill_en, fill_in;
  logic [6:0]        fill_slot;
  logic              in_image, issue, last_pixel;
  logic [ADDR_W-1:0] src_addr;

  window_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr (
    .dx      (dx),
    .dy      (dy),
    .cx      (cx),
    .cy      (cy),
    .in_image(in_image),
    .addr    (src_addr)
  );

  assign issue      = (state == S_LOAD) && (cnt <= SLOT_LAST);
  assign last_pixel = (cx == X_LAST) && (cy == Y_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    op_refresh  = 1'b0;
    res_wr_en   = 1'b0;
    res_wr_addr = '0;
    res_wr_data = '0;
    unique case (state)
      S_IDLE: if (start) next_state = S_LOAD;
      S_LOAD: begin
        busy = 1'b1;
        if (issue && in_image) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = src_addr;
        end
        if (cnt == DRAIN_CYC) next_state = S_FIRE;
      end
      S_FIRE: begin
        busy       = 1'b1;
        op_refresh = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (lat_cnt == LAT_LAST) next_state = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        res_wr_en   = 1'b1;
        res_wr_addr = centre_addr;
        res_wr_data = result;
        next_state  = last_pixel ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      dx          <= '0;
      dy          <= '0;
      cx          <= '0;
      cy          <= '0;
      centre_addr <= '0;
      lat_cnt     <= '0;
      result      <= '0;
      fill_en     <= 1'b0;
      fill_in     <= 1'b0;
      fill_slot   <= '0;
      op_data_bus <= '0;
    end else begin
      // Slot issued this cycle is filled next cycle, when read data returns.
      fill_en   <= issue;
      fill_in   <= in_image;
      fill_slot <= cnt;
      if (fill_en) op_data_bus[PIX_W*fill_slot +: PIX_W] <= fill_in ? mem_rd_data : '0;

      if (state == S_LOAD) begin
        cnt <= cnt + 7'd1;
        if (dx == D_LAST) begin
          dx <= '0;
          dy <= dy + 4'd1;
        end else begin
          dx <= dx + 4'd1;
        end
      end else begin
        cnt <= '0;
        dx  <= '0;
        dy  <= '0;
      end

      if (state == S_WAIT) begin
        if (lat_cnt == LAT_LAST) result <= op_out;
        lat_cnt <= lat_cnt + 1'b1;
      end else begin
        lat_cnt <= '0;
      end

      if (state == S_IDLE) begin
        cx          <= '0;
        cy          <= '0;
        centre_addr <= '0;
      end else if (state == S_WRITE) begin
        centre_addr <= centre_addr + 1'b1;
        if (cx == X_LAST) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_filter_window_scheduler.sv
// Bench for filter_window_scheduler: timeline model for a 3x3 frame plus a
// directed 1x1 instance with a longer datapath latency.
module tb_filter_window_scheduler;

  localparam int W = 3, H = 3, PW = 10, AW = 12, L = 2;
  localparam int N = W * H, P = 84 + L, NP = N * P;
  localparam int L1 = 5, P1 = 84 + L1;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic busy, done, mem_rd_en, op_refresh, res_wr_en;
  logic [AW-1:0] mem_rd_addr, res_wr_addr;
  logic [PW-1:0] mem_rd_data = '0, op_out = '0, res_wr_data;
  logic [81*PW-1:0] op_data_bus;

  logic start1 = 1'b0;
  logic busy1, done1, rd_en1, refresh1, wr_en1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [PW-1:0] rd_data1 = '0, op_out1 = '0, wr_data1;
  logic [81*PW-1:0] bus1;

  filter_window_scheduler #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW), .OP_LAT(L)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .op_data_bus(op_data_bus), .op_refresh(op_refresh), .op_out(op_out),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data));

  filter_window_scheduler #(.IMG_W(1), .IMG_H(1), .PIX_W(PW), .ADDR_W(AW), .OP_LAT(L1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .mem_rd_en(rd_en1), .mem_rd_addr(rd_addr1), .mem_rd_data(rd_data1),
    .op_data_bus(bus1), .op_refresh(refresh1), .op_out(op_out1),
    .res_wr_en(wr_en1), .res_wr_addr(wr_addr1), .res_wr_data(wr_data1));

  initial forever #5 clk = ~clk;

  logic [PW-1:0] img [N];
  int op_mode = 0;
  int unsigned cyc = 0, s_cyc = 0;
  bit have_frame = 0, pin45 = 0;
  int total = 0, bad = 0, rd_count = 0;

  function automatic bit active(int unsigned c);
    return have_frame && c >= s_cyc && c <= s_cyc + NP;
  endfunction

  function automatic logic [81*PW-1:0] model_win(int p);
    logic [81*PW-1:0] v = '0;
    int x, y;
    for (int k = 0; k < 81; k++) begin
      x = p % W + k % 9 - 4;
      y = p / W + k / 9 - 4;
      if (x >= 0 && x < W && y >= 0 && y < H) v[PW*k +: PW] = img[y*W+x];
    end
    return v;
  endfunction

  // Datapath stand-in: plain sum (mode 0) or slot-weighted sum (mode 1), mod 1024.
  function automatic logic [PW-1:0] op_fn(logic [81*PW-1:0] bus);
    int unsigned acc = 0;
    for (int k = 0; k < 81; k++)
      acc += int'(bus[PW*k +: PW]) * ((op_mode != 0) ? k + 1 : 1);
    return PW'(acc % 1024);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_bus(string name, logic [81*PW-1:0] act, logic [81*PW-1:0] exp);
    int first = -1;
    total++;
    for (int k = 80; k >= 0; k--)
      if (act[PW*k +: PW] !== exp[PW*k +: PW]) first = k;
    if (first >= 0) begin
      bad++;
      $display("FAIL %s: slot %0d got %0h want %0h (cycle %0d)", name, first,
               act[PW*first +: PW], exp[PW*first +: PW], cyc);
    end
  endtask

  // Frame timeline: start accepted only when the previous cycle was idle.
  initial forever begin
    @(posedge clk);
    if (!rst) have_frame = 0;
    else if (!active(cyc) && start) begin
      have_frame = 1;
      s_cyc = cyc + 1;
    end
    cyc++;
  end

  // Source memory and datapath responders for both instances.
  initial begin
    logic r_en, r1_en;
    logic [AW-1:0] r_addr;
    logic [81*PW-1:0] held, held1;
    int since = -1, since1 = -1;
    forever begin
      @(negedge clk);
      r_en = mem_rd_en; r_addr = mem_rd_addr; r1_en = rd_en1;
      if (op_refresh) begin held = op_data_bus; since = 0; end
      if (refresh1) begin held1 = bus1; since1 = 0; end
      @(posedge clk); #1;
      mem_rd_data = (r_en && int'(r_addr) < N) ? img[int'(r_addr)] : PW'($urandom);
      rd_data1 = r1_en ? 10'h3FF : PW'($urandom);
      if (since >= 0) since++;
      if (since1 >= 0) since1++;
      op_out  = (since == L) ? op_fn(held) : PW'($urandom);
      op_out1 = (since1 == L1) ? held1[PW*40 +: PW] : PW'($urandom);
      if (since == L) since = -1;
      if (since1 == L1) since1 = -1;
    end
  end

  task automatic cmp_cycle();
    logic e_busy = 0, e_done = 0, e_rd = 0, e_ref = 0, e_wr = 0, bus_chk = 0;
    logic [AW-1:0] e_ra = '0, e_wa = '0;
    logic [PW-1:0] e_wd = '0;
    logic [81*PW-1:0] e_bus = '0;
    int rel, p, ph, x, y;
    if (!rst) bus_chk = 1;
    else if (active(cyc)) begin
      rel = int'(cyc - s_cyc);
      if (rel == NP) e_done = 1;
      else begin
        e_busy = 1;
        p = rel / P;
        ph = rel % P;
        if (ph < 81) begin
          x = p % W + ph % 9 - 4;
          y = p / W + ph / 9 - 4;
          if (x >= 0 && x < W && y >= 0 && y < H) begin
            e_rd = 1;
            e_ra = AW'(y * W + x);
          end
        end else if (ph >= 82) begin
          bus_chk = 1;
          e_bus = model_win(p);
          e_ref = (ph == 82);
          if (ph == 83 + L) begin
            e_wr = 1;
            e_wa = AW'(p);
            e_wd = op_fn(e_bus);
          end
        end
      end
    end
    if (mem_rd_en) rd_count++;
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("mem_rd_en", mem_rd_en, e_rd);
    if (e_rd || mem_rd_en) chk("mem_rd_addr", mem_rd_addr, e_ra);
    chk("op_refresh", op_refresh, e_ref);
    chk("res_wr_en", res_wr_en, e_wr);
    if (e_wr || res_wr_en) begin
      chk("res_wr_addr", res_wr_addr, e_wa);
      chk("res_wr_data", res_wr_data, e_wd);
    end
    if (e_wr && pin45) chk("res_is_45", res_wr_data, 45);
    if (bus_chk) chk_bus("window", op_data_bus, e_bus);
  endtask

  initial forever begin
    @(negedge clk);
    cmp_cycle();
  end

  task automatic wait_for_done(output int unsigned when);
    when = 0;
    for (int i = 0; i < NP + 20; i++) begin
      @(negedge clk);
      if (done) begin
        when = cyc;
        return;
      end
    end
    total++; bad++;
    $display("FAIL done_timeout: got no done want done within %0d cycles", NP + 20);
  endtask

  initial begin
    int unsigned t0, d1, d2;
    logic [81*PW-1:0] e1;
    int e, kdx, kdy;
    bit seen;

    for (int i = 0; i < N; i++) img[i] = PW'(i + 1);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;

    // Frame 1: memory = address+1, plain sum -> every result is 45.
    rd_count = 0; pin45 = 1; t0 = cyc; start = 1;
    @(posedge clk); #1 start = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = op_refresh;
    end
    chk("first_refresh_seen", seen, 1);
    if (seen) begin
      chk("slot40_literal", op_data_bus[PW*40 +: PW], 1);
      chk("slot60_literal", op_data_bus[PW*60 +: PW], 9);
      for (int k = 0; k < 81; k++) begin
        kdy = k / 9; kdx = k % 9;
        e = (kdy >= 4 && kdy <= 6 && kdx >= 4 && kdx <= 6) ? (kdy - 4) * 3 + kdx - 3 : 0;
        chk("pin_slot", op_data_bus[PW*k +: PW], e);
      end
    end
    wait_for_done(d1);
    chk("frame_time", d1 - t0, NP + 1);
    chk("rd_count", rd_count, 81);
    pin45 = 0;
    @(posedge clk); #1;

    // Reset mid-LOAD, then restart from (0,0) with random pixels.
    for (int i = 0; i < N; i++) img[i] = PW'($urandom);
    op_mode = 1;
    start = 1;
    @(posedge clk); #1 start = 0;
    repeat (30) @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_strobes", {27'b0, busy, done, mem_rd_en, op_refresh, res_wr_en}, 0);
    chk("rst_bus_zero", op_data_bus == '0, 1);
    @(posedge clk); #1 rst = 1;
    t0 = cyc; start = 1;
    @(posedge clk); #1 start = 0;
    wait_for_done(d1);
    chk("frame_time_after_rst", d1 - t0, NP + 1);
    @(posedge clk); #1;

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) img[i] = PW'($urandom);
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      start = 1;
      @(posedge clk); #1 start = 0;
      wait_for_done(d1);
      @(posedge clk); #1;
    end

    // start held high: second frame only after done.
    start = 1;
    wait_for_done(d1);
    wait_for_done(d2);
    @(posedge clk); #1 start = 0;
    chk("held_start_gap", d2 - d1, NP + 2);
    repeat (5) @(posedge clk); #1;
    chk("idle_after_held", busy, 0);

    // 1x1 image, identity on slot 40, OP_LAT=5.
    start1 = 1;
    @(posedge clk); #1 start1 = 0;
    e1 = '0;
    e1[PW*40 +: PW] = 10'h3FF;
    for (int j = 0; j <= P1; j++) begin
      @(negedge clk);
      chk("x1_busy", busy1, j < P1);
      chk("x1_done", done1, j == P1);
      chk("x1_rd_en", rd_en1, j == 40);
      if (rd_en1) chk("x1_rd_addr", rd_addr1, 0);
      chk("x1_refresh", refresh1, j == 82);
      if (j == 82) chk_bus("x1_window", bus1, e1);
      chk("x1_wr_en", wr_en1, j == P1 - 1);
      if (j == P1 - 1) begin
        chk("x1_wr_addr", wr_addr1, 0);
        chk("x1_wr_data", wr_data1, 10'h3FF);
      end
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
